mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the single `mem_system` cache/memory block. It shares that block between the instruction-fetch port (read-only) and the data port (read/write). It latches one request at a time, issues it to `mem_system` as a one-cycle Rd/Wr pulse, waits for `Done`, then returns data, hit and done to the owning requester. Ties are resolved round-robin.

## Interface
- Parameters:
  - TIMEOUT_CYCLES, 64: watchdog limit in WAIT. Used only with ARB_TIMEOUT_EN.
  - AW, 16: address width.
  - DW, 16: data width.
- Ports:
  - clk  in  1  single clock, all state on rising edge.
  - rst  in  1  synchronous, active-high reset.
  - i_rd  in  1  instruction-port read request (level, held until i_done).
  - i_addr  in  AW  instruction-port address.
  - i_data_out  out  DW  instruction read data, valid when i_done=1.
  - i_done, i_stall, i_hit  out  1 each  instruction-port status.
  - d_rd, d_wr  in  1 each  data-port requests (level, held until d_done).
  - d_addr  in  AW  data-port address.
  - d_data_in  in  DW  data-port write data.
  - d_data_out  out  DW  data-port read data.
  - d_done, d_stall, d_hit  out  1 each  data-port status.
  - createdump  in  1  passed straight to mem_createdump.
  - mem_addr, mem_data_in  out  AW/DW  to mem_system Addr/DataIn.
  - mem_rd, mem_wr, mem_createdump  out  1 each  to mem_system.
  - mem_data_out  in  DW  from mem_system.
  - mem_done, mem_stall, mem_hit, mem_err  in  1 each  from mem_system.
  - err  out  1  sticky arbiter error.

## Operation
- States: IDLE=0, ISSUE=1, WAIT=2, RESP=3, ERR=4. Reset leads to IDLE.
- **IDLE:**
  - If d_rd&d_wr, go to ERR.
  - Otherwise, if any request is present, pick an owner, latch addr/data/op into the owner registers, and go to ISSUE.
- **Owner pick:**
  - A single requester wins.
  - If both request, the winner is the port not granted last. last_grant resets to D, so the first tie goes to I.
  - last_grant updates on each grant.
- **ISSUE:**
  - mem_rd or mem_wr = 1 for exactly this cycle.
  - mem_addr and mem_data_in come from the latched registers.
  - Next state is WAIT.
- **WAIT:**
  - mem_rd = mem_wr = 0. mem_addr/mem_data_in stay driven from the latches.
  - mem_err=1 → ERR.
  - mem_done=1 → latch mem_data_out and mem_hit, then go to RESP.
  - Otherwise stay in WAIT.
- **RESP:**
  - Owner's x_done = 1 for one cycle, with x_data_out and x_hit from the latches.
  - Next state is IDLE.
- **ERR:** absorbing until rst. err=1, mem_rd=mem_wr=0, all done=0, all stall=1.
- **Stall:** x_stall = request from port x & ~(state==RESP & owner==x).
- **Reset values:** state IDLE; all done/hit/stall/err = 0; mem_rd=mem_wr=0; data/addr outputs 0; last_grant = D.
- Requests arriving while busy are not latched. They stay stalled until the next IDLE sample.

## Timing
- A request is sampled at the edge ending cycle k (IDLE). ISSUE runs in k+1, WAIT from k+2.
- mem_done seen in cycle m gives RESP (x_done) in m+1 and IDLE in m+2.
- Minimum latency is 3 cycles, request to done (mem_done in the first WAIT cycle).
- The requester deasserts in cycle m+2, before the IDLE sampling edge. A still-high request in m+2 is treated as a new request.
- mem_done is ignored outside WAIT. mem_err outside WAIT is ignored.
- rst mid-transaction gives IDLE on the next edge. The outstanding mem_system access is abandoned; the caller resets mem_system too.

## Configuration
- ARB_TIMEOUT_EN:
  - When defined, an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES without mem_done, go to ERR.
  - When undefined, there is no counter and WAIT may last indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - state encoding constants IDLE..ERR;
  - port IDs PORT_I=0, PORT_D=1;
  - default AW/DW.
- One sub-module, arb_rr_pick (combinational two-input round-robin picker): inputs req[1:0] and last_grant; outputs gnt_valid and gnt_id.

## Test plan
- Reset, then i_rd=1, i_addr=0x0010, mem_done in the first WAIT cycle with mem_data_out=0xBEEF. Required: mem_rd pulse one cycle; i_done at cycle 4 with i_data_out=0xBEEF; i_stall high until then.
- i_rd and d_rd rise in the same cycle. Required: I is served first and d_stall stays high. D is then served, and the next tie grants D→… alternates I/D.
- d_wr=1, d_addr=0x0024, d_data_in=0x1234. Required: mem_wr=1 for exactly one cycle, mem_addr=0x0024, mem_data_in=0x1234, and d_done after mem_done.
- d_rd=d_wr=1 in IDLE. Required: state ERR and err=1 held across 10 cycles; rst clears it to IDLE.
- mem_err=1 in WAIT. Required: ERR. rst asserted mid-WAIT in a separate run gives IDLE with all outputs at reset values.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_done held 0. Required: ERR reached after 8 WAIT cycles. Without the macro, still in WAIT after 100 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port mem_system arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and mem_system-side signals of the arbiter; master = arbiter, slave = environment.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data_out;
    logic          i_done;
    logic          i_stall;
    logic          i_hit;

    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data_in;
    logic [DW-1:0] d_data_out;
    logic          d_done;
    logic          d_stall;
    logic          d_hit;

    logic          createdump;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_createdump;
    logic [DW-1:0] mem_data_out;
    logic          mem_done;
    logic          mem_stall;
    logic          mem_hit;
    logic          mem_err;
    logic          err;

    modport master (
        input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, createdump,
               mem_data_out, mem_done, mem_stall, mem_hit, mem_err,
        output i_data_out, i_done, i_stall, i_hit,
               d_data_out, d_done, d_stall, d_hit,
               mem_addr, mem_data_in, mem_rd, mem_wr, mem_createdump, err
    );

    modport slave (
        output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, createdump,
               mem_data_out, mem_done, mem_stall, mem_hit, mem_err,
        input  i_data_out, i_done, i_stall, i_hit,
               d_data_out, d_done, d_stall, d_hit,
               mem_addr, mem_data_in, mem_rd, mem_wr, mem_createdump, err
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational two-input round-robin picker: on a tie the port not granted last wins.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_I;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[PORT_D]) begin
            gnt_id = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch port and the data port, one request at a time.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_e    state_q, state_d;
    logic          owner_q, last_grant_q, is_wr_q, hit_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    logic [1:0]    req;
    logic          gnt_valid, gnt_id;
    logic          timed_out;
    logic          rd_pulse, wr_pulse, i_done_c, d_done_c, i_stall_c, d_stall_c, err_c;

    assign req = {bus.d_rd | bus.d_wr, bus.i_rd};

    arb_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Fires in the last permitted WAIT cycle so ERR follows exactly TIMEOUT_CYCLES WAIT cycles.
    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_D;
            is_wr_q      <= 1'b0;
            hit_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == ISSUE) begin
                owner_q      <= gnt_id;
                last_grant_q <= gnt_id;
                is_wr_q      <= (gnt_id == PORT_D) && bus.d_wr;
                addr_q       <= (gnt_id == PORT_D) ? bus.d_addr : bus.i_addr;
                wdata_q      <= (gnt_id == PORT_D) ? bus.d_data_in : '0;
            end
            if (state_q == WAIT && state_d == RESP) begin
                rdata_q <= bus.mem_data_out;
                hit_q   <= bus.mem_hit;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.d_rd && bus.d_wr) begin
                    state_d = ERR;
                end else if (gnt_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mem_err) begin
                    state_d = ERR;
                end else if (bus.mem_done) begin
                    state_d = RESP;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_pulse = 1'b0;
        wr_pulse = 1'b0;
        i_done_c = 1'b0;
        d_done_c = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            ISSUE: begin
                rd_pulse = ~is_wr_q;
                wr_pulse = is_wr_q;
            end
            RESP: begin
                i_done_c = (owner_q == PORT_I);
                d_done_c = (owner_q == PORT_D);
            end
            ERR:     err_c = 1'b1;
            default: ;
        endcase
        i_stall_c = (req[PORT_I] & ~i_done_c) | err_c;
        d_stall_c = (req[PORT_D] & ~d_done_c) | err_c;
    end

    assign bus.mem_rd         = rd_pulse;
    assign bus.mem_wr         = wr_pulse;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_data_in    = wdata_q;
    assign bus.mem_createdump = bus.createdump;
    assign bus.i_done         = i_done_c;
    assign bus.d_done         = d_done_c;
    assign bus.i_hit          = i_done_c & hit_q;
    assign bus.d_hit          = d_done_c & hit_q;
    assign bus.i_stall        = i_stall_c;
    assign bus.d_stall        = d_stall_c;
    assign bus.i_data_out     = rdata_q;
    assign bus.d_data_out     = rdata_q;
    assign bus.err            = err_c;

    // mem_stall carries no information the Done handshake does not already give.
    logic unused_ok;
    assign unused_ok = bus.mem_stall ^ (TIMEOUT_CYCLES == 0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected responses, a forked monitor checks each done.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.TIMEOUT_CYCLES(8), .AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic [15:0] data;
        logic        hit;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   t0;
    bit   ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, 32'({bus.err, bus.i_done, bus.d_done, bus.i_hit, bus.d_hit,
                                     bus.i_stall, bus.d_stall, bus.mem_rd, bus.mem_wr}), 32'h0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 32'h0);
        check({tag, "_data_out"}, 32'({bus.i_data_out, bus.d_data_out}), 32'h0);
    endtask

    // Returns at the negedge of the ISSUE cycle, or after a bounded wait.
    task automatic wait_issue(output bit seen);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_rd || bus.mem_wr) && n < 10);
        seen = bus.mem_rd || bus.mem_wr;
        check("issue_seen", 32'(seen), 32'h1);
    endtask

    // Plays mem_system: checks the issue pulse, then raises Done after lat WAIT cycles.
    // Returns at posedge+1 of the RESP cycle.
    task automatic mem_respond(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] rdata, input logic hit, input int lat);
        bit seen;
        wait_issue(seen);
        if (!seen) return;
        check("mem_wr", 32'(bus.mem_wr), 32'(wr));
        check("mem_rd", 32'(bus.mem_rd), 32'(!wr));
        check("mem_addr", 32'(bus.mem_addr), 32'(addr));
        if (wr) check("mem_data_in", 32'(bus.mem_data_in), 32'(wdata));
        step();
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                bus.mem_done     = 1'b1;
                bus.mem_data_out = rdata;
                bus.mem_hit      = hit;
            end
            @(negedge clk);
            if (k == 0) begin
                check("mem_pulse_one_cycle", 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
                check("mem_addr_held", 32'(bus.mem_addr), 32'(addr));
                check("stall_in_wait", 32'(bus.i_stall | bus.d_stall), 32'h1);
            end
            step();
        end
        bus.mem_done     = 1'b0;
        bus.mem_hit      = 1'b0;
        bus.mem_data_out = 16'hDEAD;
    endtask

    task automatic monitor;
        forever begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) begin
                logic        port;
                logic [15:0] data;
                logic        hit;
                exp_t        e;
                port = bus.d_done;
                data = port ? bus.d_data_out : bus.i_data_out;
                hit  = port ? bus.d_hit : bus.i_hit;
                $display("txn port=%s data=%h hit=%b cycle=%0d", port ? "D" : "I", data, hit, cyc);
                check("single_done", 32'(bus.i_done & bus.d_done), 32'h0);
                check("done_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("done_port", 32'(port), 32'(e.port));
                    check("done_data", 32'(data), 32'(e.data));
                    check("done_hit", 32'(hit), 32'(e.hit));
                    check("owner_not_stalled", 32'(port ? bus.d_stall : bus.i_stall), 32'h0);
                    if (e.cyc >= 0) check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    initial begin
        bus.i_rd = 0; bus.i_addr = '0; bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = '0;
        bus.d_data_in = '0; bus.createdump = 0; bus.mem_data_out = '0; bus.mem_done = 0;
        bus.mem_stall = 0; bus.mem_hit = 0; bus.mem_err = 0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1);
            end
        join_none

        // Reset values and createdump pass-through
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        bus.createdump = 1'b1;
        #1 check("createdump", 32'(bus.mem_createdump), 32'h1);
        bus.createdump = 1'b0;
        step();
        rst = 1'b0;

        // Single fetch, Done in first WAIT cycle: done three cycles after the request
        bus.i_rd = 1; bus.i_addr = 16'h0010; t0 = cyc;
        exp_q.push_back('{PORT_I, 16'hBEEF, 1'b1, t0 + 3});
        @(negedge clk);
        check("i_stall_request", 32'(bus.i_stall), 32'h1);
        mem_respond(1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b1, 0);
        step(); bus.i_rd = 0;
        step();

        // Tie after reset goes to I; D stays stalled and is served next
        do_reset();
        bus.i_rd = 1; bus.i_addr = 16'h0100; bus.d_rd = 1; bus.d_addr = 16'h0200; t0 = cyc;
        exp_q.push_back('{PORT_I, 16'h1111, 1'b0, t0 + 4});
        exp_q.push_back('{PORT_D, 16'h2222, 1'b1, -1});
        mem_respond(1'b0, 16'h0100, 16'h0, 16'h1111, 1'b0, 1);
        @(negedge clk);
        check("tie_d_stall", 32'(bus.d_stall), 32'h1);
        step(); bus.i_rd = 0;
        mem_respond(1'b0, 16'h0200, 16'h0, 16'h2222, 1'b1, 0);
        step(); bus.d_rd = 0;
        step();

        // Last grant D: next tie goes to I
        bus.i_rd = 1; bus.i_addr = 16'h0300; bus.d_rd = 1; bus.d_addr = 16'h0400; t0 = cyc;
        exp_q.push_back('{PORT_I, 16'h3333, 1'b1, t0 + 3});
        mem_respond(1'b0, 16'h0300, 16'h0, 16'h3333, 1'b1, 0);
        step(); bus.i_rd = 0; bus.d_rd = 0;
        step();

        // Last grant I: next tie goes to D, then the held I request
        bus.i_rd = 1; bus.i_addr = 16'h0500; bus.d_rd = 1; bus.d_addr = 16'h0600; t0 = cyc;
        exp_q.push_back('{PORT_D, 16'h6666, 1'b0, t0 + 3});
        exp_q.push_back('{PORT_I, 16'h5555, 1'b0, -1});
        mem_respond(1'b0, 16'h0600, 16'h0, 16'h6666, 1'b0, 0);
        step(); bus.d_rd = 0;
        mem_respond(1'b0, 16'h0500, 16'h0, 16'h5555, 1'b0, 2);
        step(); bus.i_rd = 0;
        step();

        // Data write
        bus.d_wr = 1; bus.d_addr = 16'h0024; bus.d_data_in = 16'h1234; t0 = cyc;
        exp_q.push_back('{PORT_D, 16'hA5A5, 1'b1, t0 + 5});
        mem_respond(1'b1, 16'h0024, 16'h1234, 16'hA5A5, 1'b1, 2);
        step(); bus.d_wr = 0;
        step();

        // d_rd & d_wr together: sticky ERR, stray Done ignored, rst clears
        bus.d_rd = 1; bus.d_wr = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.mem_done = (i == 4);
            @(negedge clk);
            check("err_sticky", 32'({bus.err, bus.i_stall, bus.d_stall}), 32'h7);
            check("err_quiet", 32'({bus.mem_rd, bus.mem_wr, bus.i_done, bus.d_done}), 32'h0);
            step();
        end
        bus.mem_done = 0;
        rst = 1; bus.d_rd = 0; bus.d_wr = 0;
        step(); rst = 0;
        @(negedge clk);
        check_reset_outputs("err_clear");
        step();

        // mem_err during WAIT
        bus.i_rd = 1; bus.i_addr = 16'h0077;
        wait_issue(ok);
        step(); bus.mem_err = 1;
        @(negedge clk);
        check("mem_err_wait_before", 32'(bus.err), 32'h0);
        step(); bus.mem_err = 0;
        @(negedge clk);
        check("mem_err_to_err", 32'({bus.err, bus.i_done}), 32'h2);
        step(); bus.i_rd = 0;
        do_reset();

        // rst in the middle of WAIT
        bus.d_wr = 1; bus.d_addr = 16'h0055; bus.d_data_in = 16'h9999;
        wait_issue(ok);
        step(); step();
        rst = 1; bus.d_wr = 0;
        step(); rst = 0;
        @(negedge clk);
        check_reset_outputs("rst_mid_wait");
        step(); bus.mem_done = 1;
        step(); bus.mem_done = 0;
        @(negedge clk);
        check("done_ignored_idle", 32'({bus.i_done, bus.d_done, bus.err}), 32'h0);
        step();

        // Watchdog behaviour with Done held low
        bus.i_rd = 1; bus.i_addr = 16'h0088;
        wait_issue(ok);
        step();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("timeout_still_wait", 32'(bus.err), 32'h0);
            step();
        end
        @(negedge clk);
        check("timeout_err", 32'(bus.err), 32'h1);
`else
        repeat (100) step();
        @(negedge clk);
        check("no_timeout_wait", 32'({bus.err, bus.i_stall, bus.i_done, bus.mem_rd}), 32'h4);
`endif
        step(); bus.i_rd = 0;
        do_reset();
        step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
